// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encoding, FSM states, width.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one shift-add/subtract step per cycle.
// Divide datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    input  logic            kill,
    output logic            reg_write_en,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            busy,
    output logic            err
);
    import muldiv_pkg::*;

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [4:0]        rd_q, cnt_q, rd_addr_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q, rd_data_q;
    logic              neg_q, bypass_q;

    logic              accept, a_neg, b_neg, res_neg, special;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res, hi_d, lo_d, result;
    logic [XLEN:0]     add_a, add_b;
    logic              add_c;
    logic [XLEN+1:0]   sum;
    logic [2*XLEN-1:0] prod, prod_s;

    assign accept = in_valid && in_ready;

    // Operand decode: magnitudes, result sign and the short-circuit cases.
    always_comb begin
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        res_neg  = 1'b0;
        special  = 1'b0;
        spec_res = '0;
        case (op_e'(funct3))
            OP_MULH, OP_DIV, OP_REM: begin
                a_neg = rs1_data[XLEN-1];
                b_neg = rs2_data[XLEN-1];
            end
            OP_MULHSU: a_neg = rs1_data[XLEN-1];
            default: ;
        endcase
        case (op_e'(funct3))
            OP_MULH, OP_MULHSU, OP_DIV: res_neg = a_neg ^ b_neg;
            OP_REM:                     res_neg = a_neg;
            default:                    res_neg = 1'b0;
        endcase
`ifdef MULDIV_DIV_EN
        if (funct3[2]) begin
            if (rs2_data == '0) begin
                special  = 1'b1;
                spec_res = funct3[1] ? rs1_data : '1;
            end else if (!funct3[0] && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1) begin
                special  = 1'b1;
                spec_res = funct3[1] ? '0 : rs1_data;
            end
        end
`else
        if (funct3[2]) begin
            special  = 1'b1;
            spec_res = '0;
        end
`endif
    end

    assign a_mag = a_neg ? -rs1_data : rs1_data;
    assign b_mag = b_neg ? -rs2_data : rs2_data;

    // One adder serves both: hi+multiplicand for multiply, {rem,next bit}-divisor for divide.
    always_comb begin
        add_a = {1'b0, hi_q};
        add_b = {1'b0, opnd_q};
        add_c = 1'b0;
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
            add_a = {hi_q, lo_q[XLEN-1]};
            add_b = ~{1'b0, opnd_q};
            add_c = 1'b1;
        end
`endif
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_c};
        if (lo_q[0]) begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[XLEN-1:1]};
            lo_d = {hi_q[0], lo_q[XLEN-1:1]};
        end
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
            hi_d = sum[XLEN+1] ? sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], sum[XLEN+1]};
        end
`endif
    end

`ifndef MULDIV_DIV_EN
    logic unused_sum_msb;
    assign unused_sum_msb = sum[XLEN+1];
`endif

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        if (bypass_q)
            result = lo_q;
`ifdef MULDIV_DIV_EN
        else if (op_q[2])
            result = op_q[1] ? (neg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
`endif
        else if (op_q[1:0] == 2'b00)
            result = prod_s[XLEN-1:0];
        else
            result = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            bypass_q  <= 1'b0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= funct3;
                rd_q     <= rd_addr_in;
                cnt_q    <= '0;
                hi_q     <= '0;
                neg_q    <= res_neg;
                bypass_q <= special;
                if (special) begin
                    lo_q   <= spec_res;
                    opnd_q <= b_mag;
                end else if (funct3[2]) begin
                    lo_q   <= a_mag;
                    opnd_q <= b_mag;
                end else begin
                    lo_q   <= b_mag;
                    opnd_q <= a_mag;
                end
            end else if (state_q == S_CALC) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + 5'd1;
            end
            if (state_q == S_DONE) begin
                rd_data_q <= result;
                rd_addr_q <= rd_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill)
            state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_d = special ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == 5'd31) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state_q == S_IDLE) && !kill;
        busy         = (state_q != S_IDLE);
        reg_write_en = (state_q == S_DONE) && (rd_q != 5'd0) && !kill;
        rd_data      = (state_q == S_DONE) ? result : rd_data_q;
        rd_addr      = (state_q == S_DONE) ? rd_q : rd_addr_q;
`ifdef MULDIV_DIV_EN
        err          = 1'b0;
`else
        err          = (state_q == S_DONE) && bypass_q && op_q[2];
`endif
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit; adapts to MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        kill = 1'b0;
    logic        reg_write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_addr_in(rd_addr_in), .kill(kill), .reg_write_en(reg_write_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err)
    );

    int nchecks = 0;
    int nerrs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input bit exp_err);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.rd = rd;
        v.exp = exp; v.lat = lat; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        funct3 = f3; rs1_data = a; rs2_data = b; rd_addr_in = rd; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int pulses,
                          output bit err_seen, output bit ready_bad, output bit timeout);
        lat = 0; pulses = 0; err_seen = 1'b0; ready_bad = 1'b0; timeout = 1'b1;
        start_op(f3, a, b, rd);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (reg_write_en) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            if (err) err_seen = 1'b1;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            if (in_ready) ready_bad = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, pulses, writes;
        bit err_seen, ready_bad, timeout;
        logic [4:0] prev_addr;

        add("mul_7x-3",       3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
        add("mulhu_max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, 1'b0);
        add("mulh_min",       3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 33, 1'b0);
        add("mulhsu_neg",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 1'b0);
        add("mulh_-2x3",      3'b001, 32'hFFFF_FFFE, 32'd3,         5'd9,  32'hFFFF_FFFF, 33, 1'b0);
        add("mul_big_low",    3'b000, 32'h0001_0003, 32'h0001_0005, 5'd10, 32'h0008_000F, 33, 1'b0);
        add("mul_rd0",        3'b000, 32'd3,        32'd5,         5'd0,  32'd15,        0,  1'b0);
`ifdef MULDIV_DIV_EN
        add("div_-7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 33, 1'b0);
        add("rem_-7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 33, 1'b0);
        add("divu_100/7",     3'b101, 32'd100,      32'd7,         5'd13, 32'd14,        33, 1'b0);
        add("remu_100/7",     3'b111, 32'd100,      32'd7,         5'd14, 32'd2,         33, 1'b0);
        add("divu_7/0",       3'b101, 32'd7,        32'd0,         5'd15, 32'hFFFF_FFFF, 1,  1'b0);
        add("remu_7/0",       3'b111, 32'd7,        32'd0,         5'd16, 32'd7,         1,  1'b0);
        add("div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1,  1'b0);
        add("rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         1,  1'b0);
        add("div_ovf_rd0",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 0,  1'b0);
`else
        add("div_nodiv",      3'b100, 32'd8,        32'd2,         5'd4,  32'd0,         1,  1'b1);
        add("remu_nodiv",     3'b111, 32'd9,        32'd4,         5'd3,  32'd0,         1,  1'b1);
        add("div_nodiv_rd0",  3'b100, 32'd8,        32'd2,         5'd0,  32'd0,         0,  1'b1);
`endif

        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_we", {31'd0, reg_write_en}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, pulses, err_seen, ready_bad, timeout);
            check({vecs[i].name, "_timeout"}, {31'd0, timeout}, 32'd0);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_pulses"}, pulses, (vecs[i].lat != 0) ? 32'd1 : 32'd0);
            check({vecs[i].name, "_err"}, {31'd0, err_seen}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_ready_low"}, {31'd0, ready_bad}, 32'd0);
            check({vecs[i].name, "_data"}, rd_data, vecs[i].exp);
            check({vecs[i].name, "_addr"}, {27'd0, rd_addr}, {27'd0, vecs[i].rd});
        end

        // Kill at CALC cycle 10
        prev_addr = rd_addr;
        start_op(3'b000, 32'd9, 32'd9, 5'd7);
        repeat (10) @(negedge clk);
        check("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        #1;
        check("kill_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_idle", {31'd0, busy}, 32'd0);
        check("kill_ready_back", {31'd0, in_ready}, 32'd1);
        writes = 0;
        repeat (40) begin
            @(negedge clk);
            if (reg_write_en) writes++;
        end
        check("kill_no_write", writes, 32'd0);
        check("kill_addr_held", {27'd0, rd_addr}, {27'd0, prev_addr});

        // Kill together with in_valid in IDLE: must not accept
        @(negedge clk);
        funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_addr_in = 5'd20;
        in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_blocks_accept", {31'd0, busy}, 32'd0);

        run_op(3'b000, 32'd3, 32'd4, 5'd9, lat, pulses, err_seen, ready_bad, timeout);
        check("after_kill_latency", lat, 32'd33);
        check("after_kill_data", rd_data, 32'd12);
        check("after_kill_addr", {27'd0, rd_addr}, 32'd9);

        // Reset asserted mid-CALC
        start_op(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_data", rd_data, 32'd0);
        check("rst_mid_addr", {27'd0, rd_addr}, 32'd0);
        check("rst_mid_we", {31'd0, reg_write_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);
        writes = 0;
        repeat (40) begin
            @(negedge clk);
            if (reg_write_en || busy) writes++;
        end
        check("rst_no_write", writes, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
